// File: rtl/uart_cmd_decoder.sv
// UART keyboard command decoder: WASD, VT100 arrow escapes and restart
// into a one-entry move holding register plus a restart pulse.
module uart_cmd_decoder #(
  parameter int ESC_TIMEOUT = 1000000,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  output logic [1:0]        cmd_dir,
  input  logic              cmd_ready,
  output logic              new_game,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int TW = (ESC_TIMEOUT > 2) ? $clog2(ESC_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ESC_TIMEOUT - 1);

  localparam logic [7:0] B_ESC = 8'h1B;
  localparam logic [7:0] B_LBR = 8'h5B;
  localparam logic [7:0] B_SS3 = 8'h4F;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_RIGHT = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ESC_SEEN,
    CSI_SEEN
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       k_mv, k_rs;
  logic [1:0] k_dir;
  logic       a_mv;
  logic [1:0] a_dir;
  logic       mv, rs;
  logic [1:0] dir;

  always_comb begin
    k_mv  = 1'b0;
    k_rs  = 1'b0;
    k_dir = D_UP;
    unique case (1'b1)
      (rx_data == 8'h77 || rx_data == 8'h57): begin
        k_mv = 1'b1; k_dir = D_UP;
      end
      (rx_data == 8'h73 || rx_data == 8'h53): begin
        k_mv = 1'b1; k_dir = D_DOWN;
      end
      (rx_data == 8'h64 || rx_data == 8'h44): begin
        k_mv = 1'b1; k_dir = D_RIGHT;
      end
      (rx_data == 8'h61 || rx_data == 8'h41): begin
        k_mv = 1'b1; k_dir = D_LEFT;
      end
      (rx_data == 8'h72 || rx_data == 8'h52): k_rs = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_mv  = 1'b0;
    a_dir = D_UP;
    unique case (1'b1)
      (rx_data == 8'h41): begin a_mv = 1'b1; a_dir = D_UP;    end
      (rx_data == 8'h42): begin a_mv = 1'b1; a_dir = D_DOWN;  end
      (rx_data == 8'h43): begin a_mv = 1'b1; a_dir = D_RIGHT; end
      (rx_data == 8'h44): begin a_mv = 1'b1; a_dir = D_LEFT;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mv      = 1'b0;
    rs      = 1'b0;
    dir     = D_UP;
    if (rx_valid) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          mv  = k_mv;
          rs  = k_rs;
          dir = k_dir;
          if (rx_data == B_ESC) state_d = ESC_SEEN;
        end
        ESC_SEEN: begin
          if (rx_data == B_LBR || rx_data == B_SS3) begin
            state_d = CSI_SEEN;
          end else if (rx_data == B_ESC) begin
            state_d = ESC_SEEN;
          end else begin
            // Aborted escape: the byte still counts as a plain key
            state_d = IDLE;
            mv      = k_mv;
            rs      = k_rs;
            dir     = k_dir;
          end
        end
        CSI_SEEN: begin
          if (rx_data == B_ESC) begin
            state_d = ESC_SEEN;
          end else begin
            state_d = IDLE;
            mv      = a_mv;
            dir     = a_dir;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == T_LAST) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      cmd_dir   <= D_UP;
      new_game  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      new_game <= rs;
      if (rs) begin
        cmd_valid <= 1'b0;
      end else if (mv) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_dir   <= dir;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: key table, escape
// sequences, timeout boundary, back-pressure, restart and reset.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic       new_game;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int q[$];

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [1:0] d;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .ESC_TIMEOUT(16),
    .DROP_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready),
    .new_game(new_game),
    .drop_cnt(drop_cnt)
  );

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard: every accepted move must match the oldest expected one
  always @(posedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_unexpected: got dir %0d expected none",
                 cmd_dir);
      end else begin
        chk("accept_dir", int'(cmd_dir), q.pop_front());
      end
    end
  end

  task automatic send_r(input logic [7:0] b, input logic r);
    cmd_ready = r;
    rx_data   = b;
    rx_valid  = 1'b1;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_r(b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h77, 1'b1, 2'd0};
    tbl[1]  = '{8'h57, 1'b1, 2'd0};
    tbl[2]  = '{8'h73, 1'b1, 2'd1};
    tbl[3]  = '{8'h53, 1'b1, 2'd1};
    tbl[4]  = '{8'h64, 1'b1, 2'd2};
    tbl[5]  = '{8'h44, 1'b1, 2'd2};
    tbl[6]  = '{8'h61, 1'b1, 2'd3};
    tbl[7]  = '{8'h41, 1'b1, 2'd3};
    tbl[8]  = '{8'h78, 1'b0, 2'd0};
    tbl[9]  = '{8'h5B, 1'b0, 2'd0};
    tbl[10] = '{8'h43, 1'b0, 2'd0};
    tbl[11] = '{8'h4F, 1'b0, 2'd0};

    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    idle(3);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_dir", int'(cmd_dir), 0);
    chk("rst_new_game", int'(new_game), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b1;
    idle(2);

    send(8'h77);
    chk("w_valid", int'(cmd_valid), 1);
    chk("w_dir", int'(cmd_dir), 0);
    idle(3);
    chk("w_hold_valid", int'(cmd_valid), 1);
    chk("w_hold_dir", int'(cmd_dir), 0);
    q.push_back(0);
    accept();
    chk("w_acc_valid", int'(cmd_valid), 0);

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].b);
      chk($sformatf("tbl%0d_valid", i), int'(cmd_valid), int'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_dir", i), int'(cmd_dir), int'(tbl[i].d));
        q.push_back(int'(tbl[i].d));
        accept();
        chk($sformatf("tbl%0d_clr", i), int'(cmd_valid), 0);
      end
    end

    send(8'h1B); idle(9);
    send(8'h5B); idle(9);
    chk("csi_no_early", int'(cmd_valid), 0);
    send(8'h44);
    chk("csi_left_valid", int'(cmd_valid), 1);
    chk("csi_left_dir", int'(cmd_dir), 3);
    q.push_back(3);
    accept();
    send(8'h1B); idle(9);
    send(8'h4F); idle(9);
    chk("ss3_no_early", int'(cmd_valid), 0);
    send(8'h41);
    chk("ss3_up_dir", int'(cmd_dir), 0);
    q.push_back(0);
    accept();
    chk("ss3_clr", int'(cmd_valid), 0);

    send(8'h1B); idle(20);
    send(8'h5B);
    chk("tmo_lbr_ignored", int'(cmd_valid), 0);
    send(8'h41);
    chk("tmo_a_left", int'(cmd_dir), 3);
    q.push_back(3);
    accept();

    send(8'h1B); idle(15);
    send(8'h5B);
    send(8'h44);
    chk("tmo_edge_in_dir", int'(cmd_dir), 3);
    q.push_back(3);
    accept();
    send(8'h1B); idle(16);
    send(8'h5B);
    send(8'h44);
    chk("tmo_edge_out_dir", int'(cmd_dir), 2);
    q.push_back(2);
    accept();

    send(8'h1B); idle(10);
    send(8'h1B); idle(10);
    send(8'h5B);
    send(8'h42);
    chk("esc_esc_down", int'(cmd_dir), 1);
    q.push_back(1);
    accept();

    send(8'h77);
    send(8'h52);
    chk("rs_pulse", int'(new_game), 1);
    chk("rs_flush", int'(cmd_valid), 0);
    chk("rs_drop", int'(drop_cnt), 0);
    idle(1);
    chk("rs_pulse_end", int'(new_game), 0);

    send(8'h77);
    send(8'h73);
    chk("bp_dir", int'(cmd_dir), 0);
    chk("bp_drop1", int'(drop_cnt), 1);
    q.push_back(0);
    send_r(8'h64, 1'b1);
    chk("bp_swap_valid", int'(cmd_valid), 1);
    chk("bp_swap_dir", int'(cmd_dir), 2);
    chk("bp_swap_drop", int'(drop_cnt), 1);
    q.push_back(2);
    for (int i = 0; i < 300; i++) send(8'h73);
    chk("bp_sat", int'(drop_cnt), 255);
    chk("bp_sat_dir", int'(cmd_dir), 2);
    accept();
    chk("bp_clr", int'(cmd_valid), 0);

    send(8'h64);
    send(8'h1B);
    send(8'h5B);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    rst = 1'b1;
    idle(1);
    send(8'h43);
    chk("mid_c_valid", int'(cmd_valid), 0);
    chk("mid_c_dir", int'(cmd_dir), 0);
    chk("mid_c_new_game", int'(new_game), 0);
    chk("mid_c_drop", int'(drop_cnt), 0);
    send(8'h61);
    chk("post_rst_dir", int'(cmd_dir), 3);
    q.push_back(3);
    accept();

    idle(2);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
